// File: rtl/expr_pkg.sv
// Shared constants for the expression serializer: FSM encoding,
// ASCII characters and operator codes.
package expr_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIGIT = 2'd1;
    localparam logic [1:0] ST_OP    = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ASCII characters emitted on the byte stream
    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;

    // Operator codes carried on the ops bus
    localparam logic OP_PLUS = 1'b0;
    localparam logic OP_MUL  = 1'b1;

endpackage

// File: rtl/expr_char_enc.sv
// Combinational mapping from a digit or operator code to its ASCII byte.
module expr_char_enc
    import expr_pkg::*;
(
    input  logic       is_op,
    input  logic [3:0] code,
    output logic [7:0] ch
);

    // Operators use only code[0]; digits are offset from ASCII '0'
    always_comb begin
        ch = CH_ZERO + {4'h0, code};
        if (is_op) begin
            ch = (code[0] == OP_MUL) ? CH_MUL : CH_PLUS;
        end
    end

endmodule

// File: rtl/expr_tx.sv
// Serializer emitting "d op d op ... d" ASCII expressions, one byte per
// valid/ready transfer, from a latched operand/operator descriptor.
module expr_tx
    import expr_pkg::*;
#(
    parameter int unsigned MAX_TERMS = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     start,
    input  logic [3:0]               nterms,
    input  logic [4*MAX_TERMS-1:0]   digits,
    input  logic [MAX_TERMS-2:0]     ops,
    input  logic                     ready,
    output logic [7:0]               out,
    output logic                     valid,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    logic [1:0]             state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [3:0]             nterms_q, nterms_d;
    logic [4*MAX_TERMS-1:0] digits_q, digits_d;
    logic [MAX_TERMS-2:0]   ops_q, ops_d;
    logic [7:0]             out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   start_ok;
    logic [3:0]             sel_digit;
    logic                   sel_op;
    logic                   enc_is_op;
    logic [3:0]             enc_code;
    logic [7:0]             enc_ch;

    // Validate the descriptor being latched this cycle
    always_comb begin
        start_ok = (nterms != 4'd0) && (nterms <= 4'(MAX_TERMS));
        for (int unsigned k = 0; k < MAX_TERMS; k++) begin
            if ((4'(k) < nterms) && (digits[4*k +: 4] > 4'd9)) begin
                start_ok = 1'b0;
            end
        end
    end

    // FSM next state, operand index and descriptor latch
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nterms_d = nterms_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nterms_d = nterms;
                    digits_d = digits;
                    ops_d    = ops;
                    if (start_ok) begin
                        state_d = ST_DIGIT;
                        idx_d   = 4'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DIGIT: begin
                if (ready) begin
                    state_d = (idx_q == nterms_q - 4'd1) ? ST_DONE : ST_OP;
                end
            end
            ST_OP: begin
                if (ready) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_DIGIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        sel_digit = 4'd0;
        sel_op    = OP_PLUS;
        for (int unsigned k = 0; k < MAX_TERMS; k++) begin
            if (idx_d == 4'(k)) sel_digit = digits_d[4*k +: 4];
        end
        for (int unsigned k = 0; k < MAX_TERMS - 1; k++) begin
            if (idx_d == 4'(k)) sel_op = ops_d[k];
        end
        enc_is_op = (state_d == ST_OP);
        enc_code  = enc_is_op ? {3'b000, sel_op} : sel_digit;
    end

    expr_char_enc u_enc (
        .is_op (enc_is_op),
        .code  (enc_code),
        .ch    (enc_ch)
    );

    // Registered output values
    always_comb begin
        valid_d = (state_d == ST_DIGIT) || (state_d == ST_OP);
        out_d   = valid_d ? enc_ch : 8'h00;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            nterms_q <= '0;
            digits_q <= '0;
            ops_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nterms_q <= nterms_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule
